// File: rtl/stch2dec_window.sv
// Stochastic-to-decimal window converter: counts ones over 2^WLOG2 sampled bits and
// publishes the scaled count with a valid/ack handshake. Define STCH2DEC_BIPOLAR_EN for bipolar output.
module stch2dec_window #(
    parameter int ND    = 8,
    parameter int WLOG2 = 8
) (
    input  logic          CLK,
    input  logic          INIT,
    input  logic          EN,
    input  logic          S,
    input  logic          ACK,
    output logic [ND-1:0] D_OUT,
    output logic          VALID,
    output logic          BUSY,
    output logic          OVR,
    output logic [0:0]    dbg_state_o
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;
    localparam int         SHIFT   = WLOG2 - ND;

    generate
        if (WLOG2 < ND) begin : g_bad_params
            $error("stch2dec_window: WLOG2 must be >= ND");
        end
    endgenerate

    // Handshake: D_OUT is valid while VALID=1; an edge with VALID=1 and ACK=1 consumes it.
    // A completing window always loads D_OUT and sets VALID, whatever ACK does.

    logic [0:0]       state_q, state_d;
    logic [WLOG2-1:0] samp_q, samp_d;
    logic [WLOG2:0]   ones_q, ones_d;
    logic [ND-1:0]    dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic [WLOG2:0]   ones_sum;
    logic [ND-1:0]    scaled;
    logic [ND-1:0]    code;
    logic             win_last;

    assign ones_sum = ones_q + {{WLOG2{1'b0}}, S};
    assign scaled   = ones_sum[WLOG2-1:SHIFT];
    assign win_last = (samp_q == '1);

`ifdef STCH2DEC_BIPOLAR_EN
    // The offset 2^(WLOG2-1) is a multiple of 2^SHIFT, so the bipolar code is the unipolar code with its MSB flipped.
    localparam logic [ND-1:0] MSB_MASK = ND'(1) << (ND - 1);
    assign code = ones_sum[WLOG2] ? ~MSB_MASK : (scaled ^ MSB_MASK);
`else
    assign code = ones_sum[WLOG2] ? '1 : scaled;
`endif

    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        ones_d  = ones_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && ACK) begin
            valid_d = 1'b0;
        end
        if (EN) begin
            state_d = S_ACCUM;
            samp_d  = samp_q + WLOG2'(1);
            if (win_last) begin
                ones_d  = '0;
                dout_d  = code;
                valid_d = 1'b1;
                if (valid_q && !ACK) begin
                    ovr_d = 1'b1;
                end
            end else begin
                ones_d = ones_sum;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!INIT) begin
            state_q <= S_IDLE;
            samp_q  <= '0;
            ones_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            ones_q  <= ones_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign D_OUT       = dout_q;
    assign VALID       = valid_q;
    assign BUSY        = (state_q == S_ACCUM);
    assign OVR         = ovr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stch2dec_window.sv
// Bench for stch2dec_window: table of whole-window vectors, hand-written handshake/overrun/reset
// sequences, and a randomized run against a window-queue reference model.
module tb_stch2dec_window;

    localparam int ND    = 8;
    localparam int WLOG2 = 8;
    localparam int WIN   = 1 << WLOG2;
    localparam int SHIFT = WLOG2 - ND;

`ifdef STCH2DEC_BIPOLAR_EN
    localparam logic [ND-1:0] CODE_ONES  = 8'h7F;
    localparam logic [ND-1:0] CODE_ZEROS = 8'h80;
    localparam logic [ND-1:0] CODE_HALF  = 8'h00;
    localparam logic [ND-1:0] CODE_34    = 8'h40;
`else
    localparam logic [ND-1:0] CODE_ONES  = 8'hFF;
    localparam logic [ND-1:0] CODE_ZEROS = 8'h00;
    localparam logic [ND-1:0] CODE_HALF  = 8'h80;
    localparam logic [ND-1:0] CODE_34    = 8'hC0;
`endif

    logic          CLK = 1'b0;
    logic          INIT = 1'b0;
    logic          EN = 1'b0;
    logic          S = 1'b0;
    logic          ACK = 1'b0;
    logic [ND-1:0] D_OUT;
    logic          VALID;
    logic          BUSY;
    logic          OVR;
    logic [0:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int            m_bits[$];
    logic [ND-1:0] m_dout;
    bit            m_valid;
    bit            m_busy;
    bit            m_ovr;

    stch2dec_window #(.ND(ND), .WLOG2(WLOG2)) dut (
        .CLK(CLK), .INIT(INIT), .EN(EN), .S(S), .ACK(ACK),
        .D_OUT(D_OUT), .VALID(VALID), .BUSY(BUSY), .OVR(OVR),
        .dbg_state_o(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [ND-1:0] ref_code(input int c);
        int v;
`ifdef STCH2DEC_BIPOLAR_EN
        v = (c - (WIN / 2)) >>> SHIFT;
        if (v > (1 << (ND - 1)) - 1) v = (1 << (ND - 1)) - 1;
        if (v < -(1 << (ND - 1))) v = -(1 << (ND - 1));
`else
        v = c >> SHIFT;
        if (v > (1 << ND) - 1) v = (1 << ND) - 1;
`endif
        return v[ND-1:0];
    endfunction

    task automatic model_step(input bit init, input bit en, input bit s, input bit ack);
        int  c;
        bit  done;
        if (!init) begin
            m_bits.delete();
            m_dout = '0; m_valid = 0; m_busy = 0; m_ovr = 0;
            return;
        end
        done = 0;
        if (en) begin
            m_busy = 1;
            m_bits.push_back(int'(s));
            if (m_bits.size() == WIN) begin
                c = 0;
                foreach (m_bits[i]) c += m_bits[i];
                m_dout = ref_code(c);
                m_bits.delete();
                done = 1;
            end
        end
        if (done) begin
            if (m_valid && !ack) m_ovr = 1;
            m_valid = 1;
        end else if (ack && m_valid) begin
            m_valid = 0;
        end
    endtask

    // Drive on the falling edge, observe 1 time unit after the rising edge.
    task automatic step(input bit init, input bit en, input bit s, input bit ack);
        @(negedge CLK);
        INIT = init; EN = en; S = s; ACK = ack;
        @(posedge CLK);
        #1;
        model_step(init, en, s, ack);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    function automatic int pat_cycles(input int pat);
        return (pat >= 4) ? 2 * WIN - 1 : WIN;
    endfunction

    function automatic bit pat_en(input int pat, input int k);
        return (pat >= 4) ? (k % 2 == 0) : 1'b1;
    endfunction

    function automatic bit pat_s(input int pat, input int k);
        case (pat)
            0: return 1'b1;
            1: return 1'b0;
            2: return (k % 2 == 0);
            3: return (k % 4 != 3);
            4: return 1'b1;
            default: return !pat_en(pat, k);
        endcase
    endfunction

    task automatic run_window(input int pat, input bit last_ack, input bit chk_pre);
        int n;
        n = pat_cycles(pat);
        for (int k = 0; k < n; k++) begin
            step(1, pat_en(pat, k), pat_s(pat, k), (k == n - 1) ? last_ack : 1'b0);
            if (chk_pre && k == n - 2) check("valid_before_last", VALID, 0);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_dout"}, D_OUT, m_dout);
        check({tag, "_valid"}, VALID, m_valid);
        check({tag, "_busy"}, BUSY, m_busy);
        check({tag, "_ovr"}, OVR, m_ovr);
    endtask

    typedef struct {
        string         name;
        int            pat;
        logic [ND-1:0] exp_dout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"all_ones",    0, CODE_ONES};
        vecs[1] = '{"all_zeros",   1, CODE_ZEROS};
        vecs[2] = '{"alternating", 2, CODE_HALF};
        vecs[3] = '{"three_qtr",   3, CODE_34};
        vecs[4] = '{"en_gap_ones", 4, CODE_ONES};
        vecs[5] = '{"en_gap_skip", 5, CODE_ZEROS};

        // Table-driven whole windows, each from reset
        foreach (vecs[i]) begin
            do_reset(3);
            check({vecs[i].name, "_rst_dout"}, D_OUT, 0);
            check({vecs[i].name, "_rst_valid"}, VALID, 0);
            check({vecs[i].name, "_rst_busy"}, BUSY, 0);
            check({vecs[i].name, "_rst_ovr"}, OVR, 0);
            check({vecs[i].name, "_rst_state"}, dbg_state, 0);
            run_window(vecs[i].pat, 1'b0, 1'b1);
            check({vecs[i].name, "_dout"}, D_OUT, vecs[i].exp_dout);
            check({vecs[i].name, "_valid"}, VALID, 1);
            check({vecs[i].name, "_busy"}, BUSY, 1);
            check({vecs[i].name, "_ovr"}, OVR, 0);
        end

        // Handshake: ack consumes, ack without valid ignored, ack on completion edge
        do_reset(3);
        run_window(0, 1'b0, 1'b1);
        step(1, 0, 0, 1);
        check("hs_ack_valid", VALID, 0);
        check("hs_ack_dout_held", D_OUT, CODE_ONES);
        step(1, 0, 1, 1);
        check("hs_idle_ack_valid", VALID, 0);
        check("hs_idle_ack_dout", D_OUT, CODE_ONES);
        run_window(0, 1'b0, 1'b1);
        run_window(1, 1'b1, 1'b0);
        check("hs_cmp_ack_valid", VALID, 1);
        check("hs_cmp_ack_dout", D_OUT, CODE_ZEROS);
        check("hs_cmp_ack_ovr", OVR, 0);
        step(1, 0, 0, 0);
        check("hs_hold_valid", VALID, 1);

        // Overrun: two windows without ack
        do_reset(3);
        run_window(0, 1'b0, 1'b1);
        run_window(1, 1'b0, 1'b0);
        check("ovr_dout", D_OUT, CODE_ZEROS);
        check("ovr_valid", VALID, 1);
        check("ovr_set", OVR, 1);
        step(1, 1, 1, 1);
        check("ovr_ack_valid", VALID, 0);
        check("ovr_sticky", OVR, 1);
        step(0, 1, 1, 0);
        check("ovr_init_clear", OVR, 0);

        // Reset mid-window discards the partial window
        do_reset(3);
        for (int k = 0; k < 100; k++) step(1, 1, 1, 0);
        check("mid_busy", BUSY, 1);
        step(0, 1, 1, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_valid", VALID, 0);
        run_window(1, 1'b0, 1'b1);
        check("mid_dout", D_OUT, CODE_ZEROS);
        check("mid_valid", VALID, 1);
        check("mid_ovr", OVR, 0);

        // Randomized stream against the reference model
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 1499) != 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
            check_outputs("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
